shr_iter: RTL and testbench

Iterative right shifter for the dti streaming library, the counterpart of the combinational left shifter. It consumes one data word on `din` and one shift amount on `cfg`, then shifts the word right by `STEP` bits per clock. The shift is logical or arithmetic, selected by `SIGNED`. The result is presented on a registered `dout` producer. It is intended for datapaths that cannot afford a full barrel shifter: area scales with `STEP`, and latency scales with the shift amount.

---
 rtl/shr_iter.sv | 97 +++++++++
 tb/tb_shr_iter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shr_iter.sv
// Iterative right shifter: accepts a word and a shift amount together, shifts right by up to
// STEP bits per cycle (logical or arithmetic), then holds the result on a registered output.
module shr_iter #(
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned DIN    = 16,
  parameter int unsigned CFG    = 5,
  parameter int unsigned STEP   = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           din_valid_i,
  input  logic [DIN-1:0] din_data_i,
  output logic           din_ready_o,
  input  logic           cfg_valid_i,
  input  logic [CFG-1:0] cfg_data_i,
  output logic           cfg_ready_o,
  output logic           dout_valid_o,
  output logic [DIN-1:0] dout_data_o,
  input  logic           dout_ready_i
);

  localparam int unsigned CntW = $clog2(DIN + 1);
  localparam int unsigned CmpW = (CFG > CntW) ? CFG : CntW;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [DIN-1:0]  acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [CmpW-1:0] cfg_ext;
  logic [CntW-1:0] amt_clamped;
  logic [CntW-1:0] step_amt;
  logic [CntW-1:0] cnt_rem;
  logic [DIN-1:0]  acc_shr;
  logic            in_fire;

  // Clamp to DIN so over-range amounts cost at most DIN shift cycles.
  assign cfg_ext     = CmpW'(cfg_data_i);
  assign amt_clamped = (cfg_ext >= CmpW'(DIN)) ? CntW'(DIN) : CntW'(cfg_ext);
  assign step_amt    = (cnt_q > CntW'(STEP)) ? CntW'(STEP) : cnt_q;
  assign cnt_rem     = cnt_q - step_amt;

  if (SIGNED) begin : g_arith
    assign acc_shr = DIN'($signed(acc_q) >>> step_amt);
  end else begin : g_logic
    assign acc_shr = acc_q >> step_amt;
  end

  // Both inputs are consumed together; readies stay low while reset is held.
  assign in_fire      = (state_q == StIdle) & din_valid_i & cfg_valid_i & ~rst_i;
  assign din_ready_o  = in_fire;
  assign cfg_ready_o  = in_fire;
  assign dout_valid_o = (state_q == StDone);
  assign dout_data_o  = acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          acc_d   = din_data_i;
          cnt_d   = amt_clamped;
          state_d = (amt_clamped == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        acc_d = acc_shr;
        cnt_d = cnt_rem;
        if (cnt_rem == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (dout_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_shr_iter.sv
// Bench for shr_iter: three instances (logical/1, arithmetic/1, logical/4) share stimulus;
// a per-instance scoreboard checks result data and the cycle in which dout_valid rises.
module tb_shr_iter;

  logic        clk_i = 1'b0;
  logic        rst;
  logic [15:0] din_data;
  logic [4:0]  cfg_data;
  logic        din_valid, cfg_valid;
  logic [2:0]  din_rdy, cfg_rdy, vld, dout_rdy;
  logic [15:0] dat [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic [15:0] d;
    logic [4:0]  c;
    logic [15:0] eu;
    logic [15:0] es;
  } vec_t;

  exp_t sb [3][$];
  vec_t tbl [9];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  shr_iter #(.SIGNED(1'b0), .DIN(16), .CFG(5), .STEP(1)) u_log (
    .clk_i(clk_i), .rst_i(rst),
    .din_valid_i(din_valid), .din_data_i(din_data), .din_ready_o(din_rdy[0]),
    .cfg_valid_i(cfg_valid), .cfg_data_i(cfg_data), .cfg_ready_o(cfg_rdy[0]),
    .dout_valid_o(vld[0]), .dout_data_o(dat[0]), .dout_ready_i(dout_rdy[0])
  );

  shr_iter #(.SIGNED(1'b1), .DIN(16), .CFG(5), .STEP(1)) u_ari (
    .clk_i(clk_i), .rst_i(rst),
    .din_valid_i(din_valid), .din_data_i(din_data), .din_ready_o(din_rdy[1]),
    .cfg_valid_i(cfg_valid), .cfg_data_i(cfg_data), .cfg_ready_o(cfg_rdy[1]),
    .dout_valid_o(vld[1]), .dout_data_o(dat[1]), .dout_ready_i(dout_rdy[1])
  );

  shr_iter #(.SIGNED(1'b0), .DIN(16), .CFG(5), .STEP(4)) u_stp (
    .clk_i(clk_i), .rst_i(rst),
    .din_valid_i(din_valid), .din_data_i(din_data), .din_ready_o(din_rdy[2]),
    .cfg_valid_i(cfg_valid), .cfg_data_i(cfg_data), .cfg_ready_o(cfg_rdy[2]),
    .dout_valid_o(vld[2]), .dout_data_o(dat[2]), .dout_ready_i(dout_rdy[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] d, input logic [4:0] c,
                                        input bit sgn);
    int amt;
    logic signed [31:0] w;
    amt = (c > 5'd16) ? 16 : int'(c);
    w = sgn ? {{16{d[15]}}, d} : {16'h0000, d};
    return 16'(w >>> amt);
  endfunction

  function automatic int lat(input logic [4:0] c, input int step);
    int amt;
    amt = (c > 5'd16) ? 16 : int'(c);
    return (amt + step - 1) / step;
  endfunction

  // Called in the cycle where the input handshake happens.
  task automatic push_exp(input logic [4:0] c, input logic [15:0] eu, input logic [15:0] es);
    sb[0].push_back('{eu, cyc + lat(c, 1) + 1});
    sb[1].push_back('{es, cyc + lat(c, 1) + 1});
    sb[2].push_back('{eu, cyc + lat(c, 4) + 1});
  endtask

  task automatic send(input logic [15:0] d, input logic [4:0] c, input logic [15:0] eu,
                      input logic [15:0] es, input bit push);
    int n;
    din_data  = d;
    cfg_data  = c;
    din_valid = 1'b1;
    cfg_valid = 1'b1;
    #1;
    n = 0;
    while (!((&din_rdy) && (&cfg_rdy)) && n < 200) begin
      @(negedge clk_i);
      #3;
      n++;
    end
    chk("accept", {din_rdy, cfg_rdy}, 32'h3f);
    if (push) push_exp(c, eu, es);
    @(negedge clk_i);
    #2;
    din_valid = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 300) begin
      @(negedge clk_i);
      #2;
      n++;
    end
    chk("drain", sb[0].size() + sb[1].size() + sb[2].size(), 0);
  endtask

  // Output monitor: rise latency, hold stability, and data at handshake.
  initial begin
    logic [2:0]  pv;
    logic [15:0] pd [3];
    pv = '0;
    forever begin
      @(negedge clk_i);
      #4;
      for (int i = 0; i < 3; i++) begin
        if (vld[i] && !pv[i]) begin
          if (sb[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out inst %0d: got data %0h want no output", i, dat[i]);
          end else begin
            chk($sformatf("latency%0d", i), cyc, sb[i][0].due);
          end
        end
        if (vld[i] && pv[i]) chk($sformatf("hold%0d", i), dat[i], pd[i]);
        if (vld[i] && dout_rdy[i] && sb[i].size() != 0) begin
          chk($sformatf("data%0d", i), dat[i], sb[i][0].data);
          void'(sb[i].pop_front());
        end
        pv[i] = vld[i];
        pd[i] = dat[i];
      end
    end
  end

  initial begin
    tbl[0] = '{16'h8000, 5'd3,  16'h1000, 16'hF000};
    tbl[1] = '{16'h7FF0, 5'd4,  16'h07FF, 16'h07FF};
    tbl[2] = '{16'hABCD, 5'd0,  16'hABCD, 16'hABCD};
    tbl[3] = '{16'h8001, 5'd20, 16'h0000, 16'hFFFF};
    tbl[4] = '{16'hF000, 5'd7,  16'h01E0, 16'hFFE0};
    tbl[5] = '{16'h0F00, 5'd8,  16'h000F, 16'h000F};
    tbl[6] = '{16'h1234, 5'd16, 16'h0000, 16'h0000};
    tbl[7] = '{16'h9234, 5'd15, 16'h0001, 16'hFFFF};
    tbl[8] = '{16'h4000, 5'd31, 16'h0000, 16'h0000};

    rst       = 1'b1;
    din_valid = 1'b1;
    cfg_valid = 1'b1;
    din_data  = 16'hFFFF;
    cfg_data  = 5'd1;
    dout_rdy  = 3'b111;
    #12;
    chk("rst_ready", {din_rdy, cfg_rdy}, 32'h0);
    chk("rst_valid", vld, 32'h0);
    for (int i = 0; i < 3; i++) chk($sformatf("rst_data%0d", i), dat[i], 32'h0);
    din_valid = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk_i);
    #2;
    rst = 1'b0;
    @(negedge clk_i);
    #2;

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].d, tbl[i].c, tbl[i].eu, tbl[i].es, 1'b1);
      drain();
    end

    for (int i = 0; i < 10; i++) begin
      logic [15:0] d;
      logic [4:0]  c;
      d = 16'($urandom);
      c = 5'($urandom_range(0, 31));
      send(d, c, model(d, c, 1'b0), model(d, c, 1'b1), 1'b1);
      drain();
    end

    // Only one input valid: nothing may be consumed.
    din_data  = 16'h5555;
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      #3;
      chk("lone_din_ready", {din_rdy, cfg_rdy}, 32'h0);
      chk("lone_din_valid", vld, 32'h0);
    end
    din_valid = 1'b0;
    @(negedge clk_i);
    #2;

    // Output stall with a second pair waiting upstream.
    dout_rdy = 3'b000;
    send(16'h8000, 5'd3, 16'h1000, 16'hF000, 1'b1);
    begin
      int n;
      n = 0;
      while (vld != 3'b111 && n < 100) begin
        @(negedge clk_i);
        #2;
        n++;
      end
      chk("stall_all_done", vld, 32'h7);
    end
    din_data  = 16'h0F00;
    cfg_data  = 5'd8;
    din_valid = 1'b1;
    cfg_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      #3;
      chk("busy_ready", {din_rdy, cfg_rdy}, 32'h0);
    end
    @(negedge clk_i);
    #2;
    dout_rdy = 3'b111;
    #1;
    chk("hs_cycle_ready", {din_rdy, cfg_rdy}, 32'h0);
    @(negedge clk_i);
    #3;
    chk("post_hs_ready", {din_rdy, cfg_rdy}, 32'h3f);
    push_exp(5'd8, 16'h000F, 16'h000F);
    @(negedge clk_i);
    #2;
    din_valid = 1'b0;
    cfg_valid = 1'b0;
    drain();

    // Reset in cycle 4 of a 10-bit shift discards the transaction.
    send(16'h1234, 5'd10, 16'h0, 16'h0, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    rst       = 1'b1;
    din_valid = 1'b1;
    cfg_valid = 1'b1;
    #1;
    chk("rst_async_valid", vld, 32'h0);
    chk("rst_mid_ready", {din_rdy, cfg_rdy}, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst       = 1'b0;
    din_valid = 1'b0;
    cfg_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      #3;
      chk("no_out_after_rst", vld, 32'h0);
    end
    @(negedge clk_i);
    #2;
    send(16'h0F00, 5'd8, 16'h000F, 16'h000F, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
